// File: rtl/conv_1st_pkg.sv
// Shared constants and FSM encoding for the first-layer convolution output serializer.
package conv_1st_pkg;

   localparam int unsigned LANES = 40;
   localparam int unsigned DW    = 8;
   localparam int unsigned OUT_W = 32;
   localparam int unsigned DEPTH = 4;

   localparam int unsigned ROW_W = LANES * DW;
   localparam int unsigned WPR   = ROW_W / OUT_W;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned IDX_W = $clog2(WPR);

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_t;

endpackage

// File: rtl/conv_1st_row_fifo.sv
// Synchronous row FIFO: registered pointers and count, combinational head read.
module conv_1st_row_fifo #(
   parameter int unsigned WIDTH = 320,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a row when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr];

   // Row storage; no reset needed since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/conv_1st_out_ser.sv
// Captures 320-bit convolution rows into a FIFO and streams them out as 32-bit words.
module conv_1st_out_ser
   import conv_1st_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ROW_W-1:0] conv_i,
   input  logic             valid_i,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_last,
   output logic             overflow,
   output logic [CNT_W-1:0] fill
);

   ser_state_t       state_q, state_d;
   logic [ROW_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ovf_q;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [ROW_W-1:0] head;
   logic             last_word;

   conv_1st_row_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (valid_i),
      .wdata (conv_i),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fill)
   );

   assign last_word = (idx_q == IDX_W'(WPR - 1));

   // Next-state: load head row when idle or right after the last word of a row.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (dout_ready) begin
               if (!last_word) begin
                  shift_d = shift_q >> OUT_W;
                  idx_d   = idx_q + 1'b1;
               end else if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Serializer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

   // Sticky drop flag: full FIFO with no pop on the same edge loses the row.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (valid_i && fifo_full && !pop) begin
         ovf_q <= 1'b1;
      end
   end

   // Outputs forced to zero outside SEND so reset/idle show a clean bus.
   always_comb begin
      dout_valid = (state_q == SEND);
      dout       = dout_valid ? shift_q[OUT_W-1:0] : '0;
      dout_last  = dout_valid && last_word;
      overflow   = ovf_q;
   end

endmodule
